// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store sequencer.
// Converts byte-addressed load/store requests into word accesses with byte
// enables, runs a req/ack handshake with the data memory while stalling the
// pipeline, and hands the raw loaded word plus its offset and load type to
// the write-back extension stage. Misaligned accesses and bus timeouts are
// reported instead of being issued.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, flush          MEM-stage instruction valid / discard
//   in_addr, in_wdata        byte address, store data
//   in_store_type            00 none, 01 SB, 10 SH, 11 SW
//   in_reg_type              register-write mode (load codes 1..5)
//   mem_req/addr/we/wdata    word-addressed memory request (registered)
//   mem_ack, mem_rdata       memory completion strobe and read word
//   stall                    combinational pipeline freeze
//   wb_valid/rdata/byte_sel/reg_type  load result for write-back
//   misalign, bus_err        one-cycle error pulses
//   err_addr                 address of the last rejected/timed-out access
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        flush,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [1:0]  in_store_type,
    input  logic [2:0]  in_reg_type,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_rdata,
    output logic [1:0]  wb_byte_sel,
    output logic [2:0]  wb_reg_type,
    output logic        misalign,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] RT_LB  = 3'd1;
    localparam logic [2:0] RT_LH  = 3'd2;
    localparam logic [2:0] RT_LW  = 3'd3;
    localparam logic [2:0] RT_LBU = 3'd4;
    localparam logic [2:0] RT_LHU = 3'd5;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic [2:0]       rt_q;
    logic             load_q;
    logic             flushed_q;

    logic        is_load, is_store, access;
    logic        sz_byte, sz_half, sz_word;
    logic        bad_align, accept, reject;
    logic [1:0]  off;
    logic [3:0]  we_n;
    logic [31:0] wdata_n;

    // Decode the incoming request: class, size, alignment and store lanes.
    always_comb begin
        is_load  = (in_reg_type == RT_LB) || (in_reg_type == RT_LH) ||
                   (in_reg_type == RT_LW) || (in_reg_type == RT_LBU) ||
                   (in_reg_type == RT_LHU);
        is_store = (in_store_type != 2'b00);
        access   = is_load || is_store;
        off      = in_addr[1:0];
        sz_byte  = 1'b0;
        sz_half  = 1'b0;
        sz_word  = 1'b0;
        we_n     = 4'b0000;
        wdata_n  = in_wdata;

        // A store takes precedence over a simultaneous load code.
        if (is_store) begin
            case (in_store_type)
                2'b01:   sz_byte = 1'b1;
                2'b10:   sz_half = 1'b1;
                default: sz_word = 1'b1;
            endcase
        end else if (is_load) begin
            if (in_reg_type == RT_LB || in_reg_type == RT_LBU) begin
                sz_byte = 1'b1;
            end else if (in_reg_type == RT_LH || in_reg_type == RT_LHU) begin
                sz_half = 1'b1;
            end else begin
                sz_word = 1'b1;
            end
        end

        if (is_store) begin
            if (sz_byte) begin
                we_n    = 4'b0001 << off;
                wdata_n = {4{in_wdata[7:0]}};
            end else if (sz_half) begin
                we_n    = 4'b0011 << off;
                wdata_n = in_wdata << {off, 3'b000};
            end else begin
                we_n    = 4'b1111;
            end
        end

        bad_align = (sz_half && off == 2'd3) || (sz_word && off != 2'd0);
        accept    = (state == IDLE) && in_valid && !flush && access && !bad_align;
        reject    = (state == IDLE) && in_valid && !flush && access && bad_align;
        stall     = accept || (state == BUSY);
    end

    // Sequencer: IDLE accepts or rejects, BUSY holds the request, DONE releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            rt_q        <= '0;
            load_q      <= 1'b0;
            flushed_q   <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= '0;
            mem_wdata   <= '0;
            wb_valid    <= 1'b0;
            wb_rdata    <= '0;
            wb_byte_sel <= '0;
            wb_reg_type <= '0;
            misalign    <= 1'b0;
            bus_err     <= 1'b0;
            err_addr    <= '0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= BUSY;
                        cnt       <= '0;
                        mem_req   <= 1'b1;
                        mem_addr  <= in_addr[31:2];
                        mem_we    <= we_n;
                        mem_wdata <= wdata_n;
                        addr_q    <= in_addr;
                        rt_q      <= in_reg_type;
                        load_q    <= is_load && !is_store;
                        flushed_q <= 1'b0;
                    end else if (reject) begin
                        misalign <= 1'b1;
                        err_addr <= in_addr;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (flush) begin
                        flushed_q <= 1'b1;
                    end
                    // Ack beats a timeout landing in the same cycle.
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (load_q && !flushed_q && !flush) begin
                            wb_valid    <= 1'b1;
                            wb_rdata    <= mem_rdata;
                            wb_byte_sel <= addr_q[1:0];
                            wb_reg_type <= rt_q;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        bus_err  <= 1'b1;
                        err_addr <= addr_q;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected memory
// requests and write-back/error events; a monitor pops and compares them.
module tb_mem_access_unit;

    localparam logic [2:0] LB  = 3'd1;
    localparam logic [2:0] LH  = 3'd2;
    localparam logic [2:0] LW  = 3'd3;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    localparam logic [1:0] K_WB   = 2'd1;
    localparam logic [1:0] K_MIS  = 2'd2;
    localparam logic [1:0] K_BERR = 2'd3;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        chk_wdata;
    } req_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
        logic [1:0]  sel;
        logic [2:0]  rt;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [1:0]  in_store_type = '0;
    logic [2:0]  in_reg_type = '0;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_rdata;
    logic [1:0]  wb_byte_sel;
    logic [2:0]  wb_reg_type;
    logic        misalign;
    logic        bus_err;
    logic [31:0] err_addr;

    int checks = 0;
    int failures = 0;

    req_t req_q[$];
    evt_t evt_q[$];

    int          ack_delay = -1;
    logic [31:0] resp_data = '0;
    logic        force_ack = 1'b0;
    int          age = 0;
    logic        ack_sent = 1'b0;
    logic        prev_req = 1'b0;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .in_store_type(in_store_type), .in_reg_type(in_reg_type),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .wb_valid(wb_valid), .wb_rdata(wb_rdata),
        .wb_byte_sel(wb_byte_sel), .wb_reg_type(wb_reg_type),
        .misalign(misalign), .bus_err(bus_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory model: acks ack_delay cycles after mem_req rises (-1 = never).
    always @(negedge clk) begin
        mem_ack = force_ack;
        if (mem_req && !ack_sent) begin
            if (ack_delay >= 0 && age == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = resp_data;
                ack_sent  = 1'b1;
            end
            age++;
        end else if (!mem_req) begin
            age      = 0;
            ack_sent = 1'b0;
        end
    end

    // Monitor: compare requests on mem_req rise and every output event.
    always @(negedge clk) begin
        req_t r;
        evt_t e;
        logic [1:0] kind;
        if (!rst) begin
            if (mem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL req_unexpected actual_addr=%h required=none", mem_addr);
                end else begin
                    r = req_q.pop_front();
                    chk("req_addr", 32'(mem_addr), 32'(r.addr));
                    chk("req_we", 32'(mem_we), 32'(r.we));
                    if (r.chk_wdata) chk("req_wdata", mem_wdata, r.wdata);
                end
            end
            if (wb_valid || misalign || bus_err) begin
                kind = wb_valid ? K_WB : (misalign ? K_MIS : K_BERR);
                if (32'(wb_valid) + 32'(misalign) + 32'(bus_err) > 1) begin
                    checks++; failures++;
                    $display("FAIL evt_multi actual=%b%b%b required=one-hot", wb_valid, misalign, bus_err);
                end
                if (evt_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL evt_unexpected actual_kind=%0d required=none", kind);
                end else begin
                    e = evt_q.pop_front();
                    chk("evt_kind", 32'(kind), 32'(e.kind));
                    if (e.kind == K_WB) begin
                        chk("wb_rdata", wb_rdata, e.data);
                        chk("wb_byte_sel", 32'(wb_byte_sel), 32'(e.sel));
                        chk("wb_reg_type", 32'(wb_reg_type), 32'(e.rt));
                    end else begin
                        chk("err_addr", err_addr, e.data);
                    end
                end
            end
        end
        prev_req = mem_req;
    end

    function automatic req_t mk_req(input logic [29:0] a, input logic [3:0] we,
                                    input logic [31:0] wd, input logic cw);
        req_t r;
        r.addr = a; r.we = we; r.wdata = wd; r.chk_wdata = cw;
        return r;
    endfunction

    function automatic evt_t mk_evt(input logic [1:0] k, input logic [31:0] d,
                                    input logic [1:0] s, input logic [2:0] t);
        evt_t e;
        e.kind = k; e.data = d; e.sel = s; e.rt = t;
        return e;
    endfunction

    // Present one instruction for a cycle, then count stall cycles until release.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] st, input logic [2:0] rt,
                          input int flush_at, input int exp_stall);
        int  n;
        bit  done;
        @(negedge clk);
        in_valid = 1'b1; in_addr = a; in_wdata = wd;
        in_store_type = st; in_reg_type = rt;
        #1;
        n = stall ? 1 : 0;
        @(negedge clk);
        in_valid = 1'b0; in_addr = '0; in_wdata = '0;
        in_store_type = '0; in_reg_type = '0;
        done = 1'b0;
        for (int i = 1; i < 64 && !done; i++) begin
            flush = (i == flush_at);
            #1;
            if (!stall) done = 1'b1;
            else begin
                n++;
                @(negedge clk);
            end
        end
        flush = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s_stall_release actual=stuck required=release", name);
        end
        chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rdata", wb_rdata, 32'd0);
        chk("rst_wb_byte_sel", 32'(wb_byte_sel), 32'd0);
        chk("rst_wb_reg_type", 32'(wb_reg_type), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // LW, ack one cycle after req
        ack_delay = 1; resp_data = 32'hDEADBEEF;
        req_q.push_back(mk_req(30'h400, 4'b0000, '0, 1'b0));
        evt_q.push_back(mk_evt(K_WB, 32'hDEADBEEF, 2'd0, LW));
        run_op("lw", 32'h0000_1000, 32'h0, 2'b00, LW, 0, 3);

        // SB replicates the byte into every lane
        ack_delay = 0;
        req_q.push_back(mk_req(30'h800, 4'b1000, 32'hABABABAB, 1'b1));
        run_op("sb", 32'h0000_2003, 32'h123456AB, 2'b01, 3'd0, 0, 2);

        // SH shifted by one byte
        ack_delay = 2;
        req_q.push_back(mk_req(30'h800, 4'b0110, 32'h00BEEF00, 1'b1));
        run_op("sh", 32'h0000_2001, 32'h0000BEEF, 2'b10, 3'd0, 0, 4);

        // Misaligned LH and SW: pulse only, no request, no stall
        evt_q.push_back(mk_evt(K_MIS, 32'h0000_3003, 2'd0, 3'd0));
        run_op("lh_mis", 32'h0000_3003, 32'h0, 2'b00, LH, 0, 0);
        evt_q.push_back(mk_evt(K_MIS, 32'h0000_3002, 2'd0, 3'd0));
        run_op("sw_mis", 32'h0000_3002, 32'h11111111, 2'b11, 3'd0, 0, 0);

        // LBU never acked: four BUSY cycles then bus_err
        ack_delay = -1;
        req_q.push_back(mk_req(30'h1000, 4'b0000, '0, 1'b0));
        evt_q.push_back(mk_evt(K_BERR, 32'h0000_4002, 2'd0, 3'd0));
        run_op("lbu_timeout", 32'h0000_4002, 32'h0, 2'b00, LBU, 0, 5);

        // LB flushed in BUSY: no write-back, result registers untouched
        ack_delay = 3; resp_data = 32'h55555555;
        req_q.push_back(mk_req(30'h1400, 4'b0000, '0, 1'b0));
        run_op("lb_flush", 32'h0000_5001, 32'h0, 2'b00, LB, 1, 5);
        chk("flush_wb_rdata_held", wb_rdata, 32'hDEADBEEF);
        chk("flush_wb_byte_sel_held", 32'(wb_byte_sel), 32'd0);
        chk("flush_wb_reg_type_held", 32'(wb_reg_type), 32'(LW));

        // Next LW completes normally
        ack_delay = 0; resp_data = 32'hCAFEF00D;
        req_q.push_back(mk_req(30'h1801, 4'b0000, '0, 1'b0));
        evt_q.push_back(mk_evt(K_WB, 32'hCAFEF00D, 2'd0, LW));
        run_op("lw2", 32'h0000_6004, 32'h0, 2'b00, LW, 0, 2);

        // LHU at offset 2 carries byte_sel and type through
        resp_data = 32'h87654321;
        req_q.push_back(mk_req(30'h1801, 4'b0000, '0, 1'b0));
        evt_q.push_back(mk_evt(K_WB, 32'h87654321, 2'd2, LHU));
        run_op("lhu", 32'h0000_6006, 32'h0, 2'b00, LHU, 0, 2);

        // Store and load codes together behave as a store
        ack_delay = 1;
        req_q.push_back(mk_req(30'h1C00, 4'b1111, 32'hA5A50F0F, 1'b1));
        run_op("sw_lw", 32'h0000_7000, 32'hA5A50F0F, 2'b11, LW, 0, 3);

        // No access class: stays idle
        run_op("none", 32'h0000_7004, 32'h0, 2'b00, 3'd0, 0, 0);

        // Reset while BUSY drops the request; a stray ack afterwards is ignored
        ack_delay = -1;
        req_q.push_back(mk_req(30'h2400, 4'b0000, '0, 1'b0));
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'h0000_9000; in_reg_type = LW;
        @(negedge clk);
        in_valid = 1'b0; in_addr = '0; in_reg_type = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("busy_rst_mem_req", 32'(mem_req), 32'd0);
        chk("busy_rst_stall", 32'(stall), 32'd0);
        @(posedge clk); force_ack = 1'b1;
        @(posedge clk); force_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_ack_wb_rdata", wb_rdata, 32'd0);

        // Ack on the last allowed BUSY cycle wins over the timeout
        ack_delay = 3; resp_data = 32'h11223344;
        req_q.push_back(mk_req(30'h2000, 4'b0000, '0, 1'b0));
        evt_q.push_back(mk_evt(K_WB, 32'h11223344, 2'd0, LW));
        run_op("ack_at_limit", 32'h0000_8000, 32'h0, 2'b00, LW, 0, 5);

        repeat (3) @(negedge clk);
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        chk("evt_queue_drained", 32'(evt_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store sequencer between the EX/MEM pipeline register and the word-addressed data memory. It turns byte-addressed load and store requests into word accesses with byte enables, and runs a req/ack handshake with the memory while stalling the pipeline. It registers the returned word, the low address bits and the load type for the write-back data extension stage. It flags misaligned accesses and bus timeouts instead of issuing them.

## Interface
- TIMEOUT, default 255: cycles in BUSY without `mem_ack` before a bus error is declared (range 1..255).
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM-stage instruction valid.
- flush  in  1  discard the current MEM-stage instruction.
- in_addr  in  32  byte address (ALU result).
- in_wdata  in  32  store data (rs2).
- in_store_type  in  2  00 none, 01 SB, 10 SH, 11 SW.
- in_reg_type  in  3  register-write mode using the `Parameters.v` encodings; `LB`/`LH`/`LW`/`LBU`/`LHU` mark a load.
- mem_req  out  1  memory request, held until ack.
- mem_addr  out  30  word address, equal to addr[31:2].
- mem_we  out  4  byte write enables; 0000 for loads.
- mem_wdata  out  32  lane-shifted store data.
- mem_ack  in  1  one-cycle completion strobe.
- mem_rdata  in  32  read word, valid with `mem_ack`.
- stall  out  1  freeze IF–MEM stages.
- wb_valid  out  1  one-cycle pulse: a load result is ready.
- wb_rdata  out  32  raw loaded word.
- wb_byte_sel  out  2  addr[1:0] of the load.
- wb_reg_type  out  3  load mode of the result.
- misalign  out  1  one-cycle pulse: access rejected.
- bus_err  out  1  one-cycle pulse: timeout.
- err_addr  out  32  address of the last misaligned or timed-out access.

## Operation
- Access classes:
  - Load: `in_reg_type` is one of the five load codes.
  - Store: `in_store_type` ≠ 00.
  - Store and load together: treated as a store, no `wb_valid`.
  - Otherwise: no access; the block stays idle and `stall`=0.
- Alignment by offset off = addr[1:0]:
  - LB/LBU/SB: any off is legal.
  - LH/LHU/SH: off=3 is misaligned.
  - LW/SW: off≠0 is misaligned.
- Store lanes:
  - SB: we=0001<<off, wdata={4{wdata[7:0]}}.
  - SH: we=0011<<off, wdata=wdata<<(8·off).
  - SW: we=1111, wdata unchanged.
- States IDLE, BUSY, DONE.
- IDLE:
  - Legal access with in_valid & !flush: latch address, lanes, we and type; next state BUSY.
  - Misaligned access with in_valid & !flush: next cycle `misalign`=1 and err_addr=in_addr; no request; stay IDLE.
  - flush=1: ignore the input.
- BUSY:
  - `mem_req`=1; `mem_addr`, `mem_we` and `mem_wdata` stay stable from the latches.
  - Timeout counter increments each cycle.
  - On mem_ack: for a load, capture `mem_rdata` into wb_rdata; next state DONE.
  - If the counter reaches TIMEOUT without ack: `bus_err` pulse, err_addr=latched address; next state IDLE with no wb_valid.
- DONE:
  - `wb_valid`=1 for one cycle if the access was a load and not flushed. `wb_byte_sel` and `wb_reg_type` come from the latches.
  - Next state IDLE unconditionally; the held MEM-stage instruction is not re-issued.
- flush while BUSY: the transaction runs to ack or timeout; `wb_valid` is suppressed. A timeout still raises `bus_err`.
- `wb_rdata`, `wb_byte_sel` and `wb_reg_type` hold their values until the next load completes.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `wb_valid`=0, `wb_rdata`=0, `wb_byte_sel`=0, `wb_reg_type`=0.
  - `misalign`=0, `bus_err`=0, `err_addr`=0.
- Reset in BUSY drops `mem_req` on the next edge; a later `mem_ack` is ignored in IDLE.
- `stall` is combinational:
  - 1 in IDLE when in_valid & !flush & legal access.
  - 1 in BUSY.
  - 0 in DONE and otherwise.
- The pipeline advances at the end of DONE.
- `mem_req` rises the cycle after acceptance.
- Latency, acceptance to `wb_valid`: 2 + k cycles, where k = cycles from `mem_req` rise to `mem_ack` (k=0 means ack in the first BUSY cycle).
- Minimum occupancy per access is 3 cycles (IDLE, BUSY, DONE).
- Ack in the same cycle the counter hits TIMEOUT: the ack wins and there is no `bus_err`.
- All outputs other than `stall` are registered.

## Test plan
- LW at 0x0000_1000, memory acks 1 cycle after req with 0xDEADBEEF:
  - `mem_addr`=0x400, `mem_we`=0000.
  - `stall` is high for 3 cycles.
  - `wb_valid` pulses with wb_rdata=0xDEADBEEF, wb_byte_sel=00, wb_reg_type=`LW`.
- SB of 0x123456AB at 0x0000_2003: `mem_we`=1000, mem_wdata=0xABABABAB, no `wb_valid`.
- SH of 0x0000BEEF at 0x0000_2001: `mem_we`=0110, mem_wdata=0x00BEEF00.
- LH at 0x0000_3003 and SW at 0x0000_3002:
  - Each gives a `misalign` pulse with err_addr equal to the input address.
  - `mem_req` stays 0 and `stall` stays 0.
- LBU at 0x0000_4002 with TIMEOUT=4 and no ack:
  - `bus_err` pulses on the 4th BUSY cycle, err_addr=0x0000_4002.
  - No `wb_valid`; state returns to IDLE.
- LB accepted, `flush` asserted in BUSY, ack 3 cycles later: no `wb_valid` and `wb_rdata` unchanged. The next LW then completes normally.
